ingress_frame_arbiter: RTL and testbench
========================================

// Module: ingress_frame_arbiter
// PURPOSE
//  Shares the core_data_orchestrator ingress path between NUMBER_OF_PORTS receive ports (RMII + virtual).
//  Grants exactly one port at a time, round-robin, and holds the grant for a whole frame (9-bit words, bit 8 = end-of-frame).
//  Sits between the port receive_data/receive_data_valid outputs and the orchestrator receive input.
//  Aborts a stalled frame after a timeout so that no single port can hang the switch.
// PARAMETERS
//  NUMBER_OF_PORTS  4      number of requesting ports, 2..16
//  TIMEOUT_CYCLES   4096   consecutive non-transfer cycles in STREAM before the frame is aborted, >=2
// PORTS
//  clock                     in   1                    single core clock
//  reset                     in   1                    synchronous, active-high
//  port_receive_data_valid   in   NUMBER_OF_PORTS      per-port word valid
//  port_receive_data         in   NUMBER_OF_PORTS x 9  per-port word; [8]=EOF
//  port_receive_data_ready   out  NUMBER_OF_PORTS      per-port ready; only the granted bit can be 1
//  core_receive_data         out  9                    muxed word to orchestrator
//  core_receive_data_valid   out  1                    muxed valid
//  core_receive_data_ready   in   1                    orchestrator backpressure
//  grant_index               out  $clog2(NUMBER_OF_PORTS)  currently/last granted port
//  grant_active              out  1                    1 while in STREAM
//  frame_abort               out  1                    1-cycle pulse on timeout abort
//  frames_forwarded          out  16                   saturating count of completed frames
// BEHAVIOUR
//  Reset: state=IDLE, grant_index=NUMBER_OF_PORTS-1 (so port 0 has first priority), all outputs 0, counters 0.
//  Transfer: a word moves when port_receive_data_valid[g] && port_receive_data_ready[g].
//  IDLE: if any port_receive_data_valid bit is 1, pick the first set bit searching grant_index+1 upward with wrap.
//   Register that bit into grant_index and go to STREAM. Arbitration latency is 1 cycle; no words move in IDLE.
//  STREAM, combinational from registered grant g:
//   port_receive_data_ready[g] = core_receive_data_ready; all other ready bits are 0.
//   core_receive_data = port_receive_data[g].
//   core_receive_data_valid = port_receive_data_valid[g].
//  STREAM exit on EOF: a transfer with data[8]=1 returns to IDLE and increments frames_forwarded (holds at 16'hFFFF).
//   This leaves one bubble cycle between frames.
//  Outside STREAM: core_receive_data_valid=0, every ready bit=0, core_receive_data=0.
//  Timeout: stall counter clears on each transfer and on entry to STREAM, and increments on every other STREAM cycle.
//   Reaching TIMEOUT_CYCLES-1 with no transfer forces IDLE and pulses frame_abort for 1 cycle.
//   frames_forwarded does not increment. grant_index keeps the aborted port, so the next search starts after it.
//  Backpressure: core_receive_data_ready=0 counts as a stall; the timeout protects against downstream hang too.
//  Single requester: the same port is re-granted after the 1-cycle IDLE bubble.
//  Valid dropping mid-frame: grant is held; only EOF or timeout releases it.
//  Reset asserted mid-frame: return to IDLE next edge. The partial frame is dropped with no abort pulse. Priority restarts at port 0.
//  Widths: stall counter is $clog2(TIMEOUT_CYCLES+1) bits, unsigned, cannot wrap.
// STRUCTURE
//  switch_pkg holds:
//   localparam FRAME_WORD_WIDTH=9 and EOF_BIT=8.
//   typedef enum logic {IDLE, STREAM} ingress_arbiter_state_t.
//   function port_index_width(n) = $clog2(n).
//  Sub-module round_robin_select is purely combinational.
//   Inputs: request vector, last grant. Outputs: next index and found flag.
//   It is reusable for the egress scheduler.
//  The FSM, stall counter, frame counter and output mux stay in this module.
// TESTING (NUMBER_OF_PORTS=4, TIMEOUT_CYCLES=16)
//  Port 2 sends a 5-word frame (last word 9'h1AB), ready=1.
//   -> grant_index=2 one cycle after valid rises; 5 words appear in order; frames_forwarded=1; IDLE after the EOF word.
//  Ports 0, 1 and 3 request continuously with 2-word frames.
//   -> grant order is 0,1,3,0,1,3; no port is granted twice in a row while others wait.
//  Port 1 sends 3 words without EOF, then valid=0.
//   -> frame_abort pulses 16 cycles after the last transfer; next grant goes to port 2 or 3 if requesting, else port 0; counter unchanged.
//  Port 0 streams while core_receive_data_ready toggles 1,0,1,0.
//   -> words transfer only when ready=1; no duplicates or drops; ready bits 1..3 stay 0.
//  Reset is asserted for 1 cycle mid-frame on port 3.
//   -> next cycle state=IDLE, all outputs 0, grant_index=3.
//   -> with all ports requesting afterwards, port 0 is granted first.
//  frames_forwarded is forced near saturation, then 3 more frames complete.
//   -> count holds at 16'hFFFF.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared switch types: frame word layout, ingress arbiter states, index width helper.
// Pure declarations; no timing or flow-control behaviour of its own.
package switch_pkg;

  localparam int FRAME_WORD_WIDTH = 9;
  localparam int EOF_BIT          = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ingress_arbiter_state_t;

  function automatic int port_index_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/ingress_frame_arbiter_if.sv
// Ingress bundle: per-port receive words on one side, the single orchestrator stream on the other.
// master = arbiter view, slave = environment (ports + orchestrator) view.
interface ingress_frame_arbiter_if #(
  parameter int NUMBER_OF_PORTS = 4
);
  import switch_pkg::*;

  logic [NUMBER_OF_PORTS-1:0]                       port_receive_data_valid;
  logic [NUMBER_OF_PORTS-1:0][FRAME_WORD_WIDTH-1:0] port_receive_data;
  logic [NUMBER_OF_PORTS-1:0]                       port_receive_data_ready;
  logic [FRAME_WORD_WIDTH-1:0]                      core_receive_data;
  logic                                             core_receive_data_valid;
  logic                                             core_receive_data_ready;

  modport master (
    input  port_receive_data_valid,
    input  port_receive_data,
    input  core_receive_data_ready,
    output port_receive_data_ready,
    output core_receive_data,
    output core_receive_data_valid
  );

  modport slave (
    output port_receive_data_valid,
    output port_receive_data,
    output core_receive_data_ready,
    input  port_receive_data_ready,
    input  core_receive_data,
    input  core_receive_data_valid
  );

endinterface

// File: rtl/ingress_frame_arbiter_round_robin_select.sv
// Round-robin picker: first set request bit searching upward from last_grant+1 with wrap.
// Latency: purely combinational. Backpressure: none, caller decides when to register the result.
module round_robin_select
  import switch_pkg::*;
#(
  parameter  int NUMBER_OF_PORTS = 4,
  localparam int INDEX_WIDTH     = port_index_width(NUMBER_OF_PORTS)
) (
  input  logic [NUMBER_OF_PORTS-1:0] request,
  input  logic [INDEX_WIDTH-1:0]     last_grant,
  output logic [INDEX_WIDTH-1:0]     next_index,
  output logic                       found
);

  int                     candidate;
  logic [INDEX_WIDTH-1:0] candidate_index;

  // Walk from the farthest offset down so the nearest requester is the last one written.
  always_comb begin
    next_index      = last_grant;
    found           = 1'b0;
    candidate       = 0;
    candidate_index = '0;
    for (int offset = NUMBER_OF_PORTS; offset >= 1; offset--) begin
      candidate       = (int'(last_grant) + offset) % NUMBER_OF_PORTS;
      candidate_index = INDEX_WIDTH'(candidate);
      if (request[candidate_index]) begin
        next_index = candidate_index;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ingress_frame_arbiter.sv
// Frame-atomic round-robin arbiter sharing the orchestrator ingress between receive ports.
// Latency: 1-cycle grant in IDLE, then zero-latency mux; one bubble between frames.
// Backpressure: core ready passes straight to the granted port; stalled frames abort after TIMEOUT_CYCLES.
module ingress_frame_arbiter
  import switch_pkg::*;
#(
  parameter  int NUMBER_OF_PORTS = 4,
  parameter  int TIMEOUT_CYCLES  = 4096,
  localparam int INDEX_WIDTH     = port_index_width(NUMBER_OF_PORTS),
  localparam int STALL_WIDTH     = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  ingress_frame_arbiter_if.master bus,
  output logic [INDEX_WIDTH-1:0] grant_index,
  output logic                   grant_active,
  output logic                   frame_abort,
  output logic [15:0]            frames_forwarded
);

  ingress_arbiter_state_t      state_q;
  logic [INDEX_WIDTH-1:0]      grant_q;
  logic [STALL_WIDTH-1:0]      stall_q;
  logic [15:0]                 frame_count_q;
  logic [15:0]                 frame_count_next;
  logic                        abort_q;

  logic [INDEX_WIDTH-1:0]      next_index;
  logic                        found;
  logic [FRAME_WORD_WIDTH-1:0] granted_data;
  logic                        granted_valid;
  logic                        streaming;
  logic                        transfer;
  logic                        end_of_frame;
  logic                        timed_out;
  logic [NUMBER_OF_PORTS-1:0]  ready_vec;
  logic [FRAME_WORD_WIDTH-1:0] core_data;
  logic                        core_valid;

  round_robin_select #(
    .NUMBER_OF_PORTS(NUMBER_OF_PORTS)
  ) u_select (
    .request   (bus.port_receive_data_valid),
    .last_grant(grant_q),
    .next_index(next_index),
    .found     (found)
  );

  always_comb begin
    streaming     = (state_q == STREAM);
    granted_data  = bus.port_receive_data[grant_q];
    granted_valid = bus.port_receive_data_valid[grant_q];
    ready_vec     = '0;
    core_data     = '0;
    core_valid    = 1'b0;
    if (streaming) begin
      ready_vec[grant_q] = bus.core_receive_data_ready;
      core_data          = granted_data;
      core_valid         = granted_valid;
    end
    transfer     = streaming && granted_valid && bus.core_receive_data_ready;
    end_of_frame = transfer && granted_data[EOF_BIT];
    timed_out    = streaming && !transfer && (stall_q == STALL_WIDTH'(TIMEOUT_CYCLES - 1));
    frame_count_next = frame_count_q;
    if (end_of_frame && (frame_count_q != 16'hFFFF)) begin
      frame_count_next = frame_count_q + 16'd1;
    end
  end

  assign bus.port_receive_data_ready = ready_vec;
  assign bus.core_receive_data       = core_data;
  assign bus.core_receive_data_valid = core_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= INDEX_WIDTH'(NUMBER_OF_PORTS - 1);
      stall_q       <= '0;
      frame_count_q <= '0;
      abort_q       <= 1'b0;
    end else begin
      abort_q       <= 1'b0;
      frame_count_q <= frame_count_next;
      if (state_q == IDLE) begin
        if (found) begin
          grant_q <= next_index;
          state_q <= STREAM;
          stall_q <= '0;
        end
      end else if (transfer) begin
        stall_q <= '0;
        if (end_of_frame) begin
          state_q <= IDLE;
        end
      end else if (timed_out) begin
        // grant_q keeps the aborted port so the next search starts just after it
        state_q <= IDLE;
        stall_q <= '0;
        abort_q <= 1'b1;
      end else begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign grant_index      = grant_q;
  assign grant_active     = (state_q == STREAM);
  assign frame_abort      = abort_q;
  assign frames_forwarded = frame_count_q;

endmodule

// File: tb/tb_ingress_frame_arbiter.sv
// Bench for ingress_frame_arbiter: queued port sources, an ordered scoreboard of expected core words,
// an arbitration vector table and hand sequences for timeout, backpressure, reset and saturation.
module tb_ingress_frame_arbiter;

  localparam int NP = 4;
  localparam int TO = 16;

  typedef struct packed {
    logic [1:0] port;
    logic [8:0] word;
  } sb_t;

  typedef struct {
    logic [3:0] mask;
    logic [1:0] exp_grant;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        core_rdy = 1'b1;
  logic [1:0]  grant_index;
  logic        grant_active;
  logic        frame_abort;
  logic [15:0] frames_forwarded;

  logic [8:0]  src [NP][$];
  sb_t         sb[$];
  vec_t        tbl[8];
  int          n_checks = 0;
  int          n_errors = 0;

  ingress_frame_arbiter_if #(.NUMBER_OF_PORTS(NP)) bus ();

  ingress_frame_arbiter #(
    .NUMBER_OF_PORTS(NP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .bus             (bus),
    .grant_index     (grant_index),
    .grant_active    (grant_active),
    .frame_abort     (frame_abort),
    .frames_forwarded(frames_forwarded)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] word(input int eof, input int p, input int i);
    return {1'(eof), 4'(p), 4'(i)};
  endfunction

  task automatic load(input int p, input logic [8:0] w);
    src[p].push_back(w);
  endtask

  task automatic expect_word(input int p, input logic [8:0] w);
    sb_t e;
    e.port = 2'(p);
    e.word = w;
    sb.push_back(e);
  endtask

  task automatic clear_src();
    for (int p = 0; p < NP; p++) src[p].delete();
  endtask

  task automatic drive();
    logic [NP-1:0]      v;
    logic [NP-1:0][8:0] d;
    v = '0;
    d = '0;
    for (int p = 0; p < NP; p++) begin
      v[p] = (src[p].size() > 0);
      if (v[p]) d[p] = src[p][0];
    end
    bus.port_receive_data_valid = v;
    bus.port_receive_data       = d;
    bus.core_receive_data_ready = core_rdy;
  endtask

  // One clock: observe at negedge, let the edge commit, then retire accepted words and redrive.
  task automatic cycle();
    logic [NP-1:0] xfer;
    logic [NP-1:0] exp_rdy;
    sb_t           e;
    @(negedge clock);
    exp_rdy = '0;
    if (grant_active) exp_rdy[grant_index] = core_rdy;
    check("ready_mask", 32'(bus.port_receive_data_ready), 32'(exp_rdy));
    if (!grant_active)
      check("idle_core_out", 32'({bus.core_receive_data_valid, bus.core_receive_data}), 32'h0);
    if (bus.core_receive_data_valid && bus.core_receive_data_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_word: got %0h from port %0d, expected no word", bus.core_receive_data, grant_index);
      end else begin
        e = sb.pop_front();
        check("word_port", 32'(grant_index), 32'(e.port));
        check("word_data", 32'(bus.core_receive_data), 32'(e.word));
      end
    end
    xfer = bus.port_receive_data_valid & bus.port_receive_data_ready;
    @(posedge clock);
    #1;
    for (int p = 0; p < NP; p++)
      if (xfer[p] && src[p].size() > 0) void'(src[p].pop_front());
    drive();
  endtask

  task automatic run_until_empty(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    check({name, "_drained"}, 32'(sb.size()), 32'h0);
    sb.delete();
  endtask

  initial begin
    int n;
    tbl[0] = '{4'b1111, 2'd3};
    tbl[1] = '{4'b1111, 2'd0};
    tbl[2] = '{4'b0110, 2'd1};
    tbl[3] = '{4'b0011, 2'd0};
    tbl[4] = '{4'b0001, 2'd0};
    tbl[5] = '{4'b1010, 2'd1};
    tbl[6] = '{4'b0101, 2'd2};
    tbl[7] = '{4'b1000, 2'd3};

    drive();
    cycle();
    cycle();
    check("rst_active", 32'(grant_active), 32'h0);
    check("rst_grant", 32'(grant_index), 32'h3);
    check("rst_abort", 32'(frame_abort), 32'h0);
    check("rst_frames", 32'(frames_forwarded), 32'h0);
    check("rst_core_valid", 32'(bus.core_receive_data_valid), 32'h0);
    reset = 1'b0;

    // Port 2, five words ending in 9'h1AB
    for (int i = 0; i < 4; i++) begin
      load(2, word(0, 2, i));
      expect_word(2, word(0, 2, i));
    end
    load(2, 9'h1AB);
    expect_word(2, 9'h1AB);
    drive();
    cycle();
    check("p2_grant", 32'(grant_index), 32'h2);
    check("p2_active", 32'(grant_active), 32'h1);
    for (int i = 0; i < 5; i++) cycle();
    check("p2_drained", 32'(sb.size()), 32'h0);
    check("p2_idle", 32'(grant_active), 32'h0);
    check("p2_frames", 32'(frames_forwarded), 32'h1);

    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < NP; p++)
        if (tbl[i].mask[p]) load(p, word(1, p, i));
      expect_word(int'(tbl[i].exp_grant), word(1, int'(tbl[i].exp_grant), i));
      drive();
      cycle();
      check("tbl_grant", 32'(grant_index), 32'(tbl[i].exp_grant));
      check("tbl_active", 32'(grant_active), 32'h1);
      cycle();
      check("tbl_idle", 32'(grant_active), 32'h0);
      clear_src();
      drive();
    end
    check("tbl_frames", 32'(frames_forwarded), 32'd9);

    // Ports 0,1,3 each offer two 2-word frames; expect strict 0,1,3 rotation
    for (int k = 0; k < 2; k++) begin
      foreach (tbl[j]) if (j < 3) begin
        int p;
        p = (j == 2) ? 3 : j;
        load(p, word(0, p, 2 * k));
        load(p, word(1, p, 2 * k + 1));
      end
    end
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) begin
        int p;
        p = (j == 2) ? 3 : j;
        expect_word(p, word(0, p, 2 * k));
        expect_word(p, word(1, p, 2 * k + 1));
      end
    end
    drive();
    run_until_empty("rr", 60);
    check("rr_frames", 32'(frames_forwarded), 32'd15);
    check("rr_idle", 32'(grant_active), 32'h0);
    clear_src();
    drive();

    // Port 1 stalls after three words without EOF
    for (int i = 0; i < 3; i++) begin
      load(1, word(0, 1, i));
      expect_word(1, word(0, 1, i));
    end
    drive();
    cycle();
    check("to_grant", 32'(grant_index), 32'h1);
    for (int i = 0; i < 3; i++) cycle();
    load(0, word(1, 0, 9));
    load(3, word(1, 3, 9));
    expect_word(3, word(1, 3, 9));
    expect_word(0, word(1, 0, 9));
    drive();
    n = 0;
    while (!frame_abort && n < 40) begin
      cycle();
      n++;
    end
    check("to_delay", 32'(n), 32'd16);
    check("to_grant_kept", 32'(grant_index), 32'h1);
    check("to_idle", 32'(grant_active), 32'h0);
    check("to_frames", 32'(frames_forwarded), 32'd15);
    cycle();
    check("to_pulse_end", 32'(frame_abort), 32'h0);
    check("to_next_grant", 32'(grant_index), 32'h3);
    run_until_empty("to", 20);
    check("to_after_frames", 32'(frames_forwarded), 32'd17);

    // Port 0 under alternating core backpressure
    for (int i = 0; i < 6; i++) begin
      load(0, word((i == 5) ? 1 : 0, 0, i));
      expect_word(0, word((i == 5) ? 1 : 0, 0, i));
    end
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      core_rdy = (n % 2 == 0);
      drive();
      cycle();
      n++;
    end
    check("bp_drained", 32'(sb.size()), 32'h0);
    core_rdy = 1'b1;
    drive();
    check("bp_frames", 32'(frames_forwarded), 32'd18);

    // Reset mid-frame on port 3
    for (int i = 0; i < 5; i++) load(3, word(0, 3, i));
    expect_word(3, word(0, 3, 0));
    expect_word(3, word(0, 3, 1));
    drive();
    cycle();
    check("mr_grant", 32'(grant_index), 32'h3);
    cycle();
    cycle();
    core_rdy = 1'b0;
    reset = 1'b1;
    drive();
    cycle();
    check("mr_active", 32'(grant_active), 32'h0);
    check("mr_grant_rst", 32'(grant_index), 32'h3);
    check("mr_abort", 32'(frame_abort), 32'h0);
    check("mr_frames", 32'(frames_forwarded), 32'h0);
    check("mr_ready", 32'(bus.port_receive_data_ready), 32'h0);
    check("mr_core", 32'({bus.core_receive_data_valid, bus.core_receive_data}), 32'h0);
    check("mr_sb", 32'(sb.size()), 32'h0);
    reset = 1'b0;
    core_rdy = 1'b1;
    clear_src();
    for (int p = 0; p < NP; p++) begin
      load(p, word(1, p, 7));
      expect_word(p, word(1, p, 7));
    end
    drive();
    run_until_empty("mr_restart", 30);
    check("mr_frames_after", 32'(frames_forwarded), 32'd4);

    // Saturation of the frame counter
    force dut.frame_count_q = 16'hFFFD;
    cycle();
    release dut.frame_count_q;
    check("sat_preset", 32'(frames_forwarded), 32'hFFFD);
    for (int i = 0; i < 3; i++) begin
      load(1, word(1, 1, i));
      expect_word(1, word(1, 1, i));
      drive();
      run_until_empty("sat", 10);
      check("sat_count", 32'(frames_forwarded), (i == 0) ? 32'hFFFE : 32'hFFFF);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
